floor_display_ctrl: RTL and testbench
=====================================

// Module: floor_display_ctrl
// PURPOSE
//  Parametrised, registered 7-segment driver for the current floor of the elevator.
//  Converts a binary floor number to DIGITS decimal digits with a sequential
//  double-dabble (shift/add-3) engine, with a load/busy handshake.
//  Adds leading-zero blanking, an overflow indication, a blink-while-moving mode
//  and direction LEDs. Sits between the elevator controller and the panel displays.
// PARAMETERS
//  FLOOR_W     4   width of floor_in, in bits (1..20)
//  DIGITS      2   number of decimal digits driven (1..6)
//  ACTIVE_LOW  0   1 = invert every seg bit (common-anode panels)
//  LZB         1   1 = blank leading zero digits; units digit is never blanked
//  BLINK_DIV   4   clock cycles per blink half-period while moving (>=1)
// PORTS
//  clk       in   1          system clock; all state updates on the rising edge
//  rst_n     in   1          asynchronous reset, active-low
//  floor_in  in   FLOOR_W    binary floor number; sampled only when a load is accepted
//  load      in   1          conversion request; accepted only in IDLE
//  moving    in   1          1 = car in motion: enables blinking and the direction LEDs
//  dir_up    in   1          travel direction; 1 = up
//  busy      out  1          1 while a conversion is in progress
//  seg       out  7*DIGITS   seg[7*d +: 7] = digit d (d=0 = units); bit0=a .. bit6=g
//  up_led    out  1          registered (moving & dir_up)
//  dn_led    out  1          registered (moving & ~dir_up)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - FSM=IDLE, busy=0, up_led=dn_led=0, blink counter=0, blink phase=on.
//   - Display register holds value 0: units digit shows "0"; other digits are
//     blank if LZB=1, otherwise "0". Polarity is applied per ACTIVE_LOW.
//  FSM states IDLE -> CONV -> LATCH -> IDLE:
//   - IDLE: load=1 at edge E0 captures floor_in, clears the BCD shift register,
//     enters CONV and sets busy=1.
//   - CONV: runs exactly FLOOR_W shift/add-3 iterations, one per cycle.
//     The BCD register is 4*DIGITS bits wide.
//   - LATCH: copies BCD digits and the overflow flag into the display register.
//     At edge E(FLOOR_W+1), seg shows the new value and busy=0 (state IDLE).
//   - Accept-to-display latency is FLOOR_W+1 cycles.
//   - load while busy=1 is ignored; there is no queueing.
//   - The next load is accepted at the first edge where the FSM is IDLE.
//   - floor_in changes after E0 have no effect on the conversion in progress.
//  Overflow: if the captured value is >= 10^DIGITS, every digit shows "-"
//   (g only, 7'h40), regardless of LZB.
//  Segment codes, active-high:
//   0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; blank=00.
//   ACTIVE_LOW=1 inverts all bits, including blank (7'h7F).
//  Leading-zero blanking: a digit is blank iff LZB=1, it is not digit 0, and it
//   and all higher digits are 0.
//  Blink:
//   - moving=1: the counter counts 0..BLINK_DIV-1; at wrap the phase toggles.
//   - Off phase: all digits show blank.
//   - moving=0: counter=0, phase=on on the next edge, so the display is steady.
//   - Blink never alters the display register or the FSM.
//  up_led/dn_led: registered with 1-cycle latency and independent of the FSM.
//  seg is fully registered: no combinational path from any input to seg.
//  rst_n low in any state aborts the conversion immediately and restores the reset
//   values; a subsequent load behaves as the first one after reset.
// TESTING (FLOOR_W=4, DIGITS=2, ACTIVE_LOW=0, LZB=1, BLINK_DIV=4 unless noted)
//  1. Reset released, no load -> seg=14'h003F (tens blank, units "0"), busy=0,
//     leds=0.
//  2. load=1, floor_in=13 at E0 -> busy=1 for E0..E4, busy=0 at E5,
//     seg={06,4F} ("13") from E5.
//  3. load 7 at E0; load 12 at E2 (busy) -> 12 ignored; seg={00,07} at E5;
//     load 12 at E6 -> seg={06,5B} at E11.
//  4. DIGITS=1: load 12 -> seg=7'h40 ("-"); load 9 -> seg=7'h6F.
//     LZB=0: load 5 -> seg={3F,6D}.
//  5. "13" shown, moving=1, dir_up=0 -> seg toggles blank/{06,4F} every
//     4 cycles, dn_led=1, up_led=0.
//     moving=0 -> seg steady {06,4F} from the next edge, leds=0.
//  6. rst_n pulsed low 2 cycles after a load of 15 -> busy=0 and seg=14'h003F
//     immediately; a later load of 15 shows {06,6D}.

Source files
------------

// File: rtl/floor_display_ctrl.sv
// Registered 7-segment driver for the elevator floor number: sequential
// double-dabble conversion with load/busy handshake, blanking, blink and direction LEDs.
module floor_display_ctrl #(
  parameter int FLOOR_W    = 4,
  parameter int DIGITS     = 2,
  parameter int ACTIVE_LOW = 0,
  parameter int LZB        = 1,
  parameter int BLINK_DIV  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLOOR_W-1:0]    floor_in,
  input  logic                  load,
  input  logic                  moving,
  input  logic                  dir_up,
  output logic                  busy,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  up_led,
  output logic                  dn_led
);

  localparam int SEG_W  = 7 * DIGITS;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int ITER_W = (FLOOR_W > 1) ? $clog2(FLOOR_W) : 1;
  localparam int CNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [31:0] OVF_LIM = 32'(10 ** DIGITS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CONV = 2'd1, S_LATCH = 2'd2} state_t;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  function automatic logic [SEG_W-1:0] polarity(input logic [SEG_W-1:0] s);
    return (ACTIVE_LOW != 0) ? ~s : s;
  endfunction

  function automatic logic [SEG_W-1:0] reset_disp();
    logic [SEG_W-1:0] v;
    v = '0;
    for (int d = 0; d < DIGITS; d++)
      v[7*d +: 7] = (d == 0 || LZB == 0) ? 7'h3F : 7'h00;
    return v;
  endfunction

  state_t              r_state, w_state_nxt;
  logic [FLOOR_W-1:0]  r_bin;
  logic [BCD_W-1:0]    r_bcd, w_bcd_adj;
  logic [ITER_W-1:0]   r_iter;
  logic                r_ovf;
  logic [SEG_W-1:0]    r_disp, w_disp_nxt, r_seg;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_phase, w_phase_nxt;
  logic                r_up, r_dn;
  logic                w_accept, w_conv, w_latch, w_busy, w_lead;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (load) w_state_nxt = S_CONV;
      S_CONV:  if (r_iter == ITER_W'(FLOOR_W - 1)) w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept = (r_state == S_IDLE) && load;
    w_conv   = (r_state == S_CONV);
    w_latch  = (r_state == S_LATCH);
    w_busy   = (r_state != S_IDLE);
  end

  // add-3 on every BCD digit >= 5 before the shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++)
      if (r_bcd[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_iter <= '0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_bin  <= floor_in;
      r_bcd  <= '0;
      r_iter <= '0;
      r_ovf  <= (32'(floor_in) >= OVF_LIM);
    end else if (w_conv) begin
      r_bcd  <= {w_bcd_adj[BCD_W-2:0], r_bin[FLOOR_W-1]};
      r_bin  <= r_bin << 1;
      r_iter <= r_iter + ITER_W'(1);
    end
  end

  // walk from the top digit down so w_lead means "this and all higher digits are 0"
  always_comb begin
    w_disp_nxt = r_disp;
    w_lead     = 1'b1;
    if (w_latch) begin
      for (int d = DIGITS - 1; d >= 0; d--) begin
        w_lead = w_lead & (r_bcd[4*d +: 4] == 4'd0);
        if (r_ovf)                             w_disp_nxt[7*d +: 7] = 7'h40;
        else if (LZB != 0 && d != 0 && w_lead) w_disp_nxt[7*d +: 7] = 7'h00;
        else                                   w_disp_nxt[7*d +: 7] = seg_code(r_bcd[4*d +: 4]);
      end
    end
  end

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    if (!moving) begin
      w_cnt_nxt   = '0;
      w_phase_nxt = 1'b1;
    end else if (r_cnt == CNT_W'(BLINK_DIV - 1)) begin
      w_cnt_nxt   = '0;
      w_phase_nxt = ~r_phase;
    end else begin
      w_cnt_nxt   = r_cnt + CNT_W'(1);
    end
  end

  // seg is built from next-state values so it tracks display/blink with no extra lag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp  <= reset_disp();
      r_cnt   <= '0;
      r_phase <= 1'b1;
      r_seg   <= polarity(reset_disp());
      r_up    <= 1'b0;
      r_dn    <= 1'b0;
    end else begin
      r_disp  <= w_disp_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
      r_seg   <= polarity(w_phase_nxt ? w_disp_nxt : '0);
      r_up    <= moving & dir_up;
      r_dn    <= moving & ~dir_up;
    end
  end

  assign busy   = w_busy;
  assign seg    = r_seg;
  assign up_led = r_up;
  assign dn_led = r_dn;

endmodule

// File: tb/tb_floor_display_ctrl.sv
// Randomised bench for floor_display_ctrl: three parameterisations driven in parallel
// and compared each cycle against an arithmetic reference model.
module tb_floor_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0, moving = 1'b0, dir_up = 1'b0;
  logic [9:0]  fl = '0;

  logic        busy_a, busy_b, busy_c;
  logic [13:0] seg_a;
  logic [20:0] seg_b;
  logic [6:0]  seg_c;
  logic        up_a, dn_a, up_b, dn_b, up_c, dn_c;

  always #5 clk = ~clk;

  floor_display_ctrl #(.FLOOR_W(4), .DIGITS(2), .ACTIVE_LOW(0), .LZB(1), .BLINK_DIV(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .floor_in(fl[3:0]), .load(load), .moving(moving), .dir_up(dir_up),
    .busy(busy_a), .seg(seg_a), .up_led(up_a), .dn_led(dn_a));

  floor_display_ctrl #(.FLOOR_W(10), .DIGITS(3), .ACTIVE_LOW(1), .LZB(0), .BLINK_DIV(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .floor_in(fl), .load(load), .moving(moving), .dir_up(dir_up),
    .busy(busy_b), .seg(seg_b), .up_led(up_b), .dn_led(dn_b));

  floor_display_ctrl #(.FLOOR_W(4), .DIGITS(1), .ACTIVE_LOW(0), .LZB(1), .BLINK_DIV(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .floor_in(fl[3:0]), .load(load), .moving(moving), .dir_up(dir_up),
    .busy(busy_c), .seg(seg_c), .up_led(up_c), .dn_led(dn_c));

  localparam int FW [3] = '{4, 10, 4};
  localparam int DG [3] = '{2, 3, 1};
  localparam int AL [3] = '{0, 1, 0};
  localparam int LZ [3] = '{1, 0, 1};
  localparam int BD [3] = '{4, 3, 2};
  localparam logic [6:0] SEGTAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // reference model: cycles left until the new value shows, pending/shown values, blink
  int m_rem [3], m_pend [3], m_shown [3], m_cnt [3];
  bit m_ph [3];
  bit m_up, m_dn;
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int p10(input int n);
    int r = 1;
    repeat (n) r = r * 10;
    return r;
  endfunction

  function automatic logic [63:0] exp_seg(input int k);
    logic [63:0] v;
    int val;
    v   = '0;
    val = m_shown[k];
    if (m_ph[k]) begin
      for (int d = 0; d < DG[k]; d++) begin
        logic [6:0] c;
        if (val >= p10(DG[k]))                  c = 7'h40;
        else if (LZ[k] != 0 && d > 0 && val < p10(d)) c = 7'h00;
        else                                     c = SEGTAB[(val / p10(d)) % 10];
        v[7*d +: 7] = c;
      end
    end
    if (AL[k] != 0) v = v ^ ((64'd1 << (7 * DG[k])) - 64'd1);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_rem[k] = 0; m_shown[k] = 0; m_cnt[k] = 0; m_ph[k] = 1'b1;
    end
    m_up = 1'b0; m_dn = 1'b0;
  endtask

  task automatic model_step();
    m_up = moving & dir_up;
    m_dn = moving & ~dir_up;
    for (int k = 0; k < 3; k++) begin
      if (!moving) begin
        m_cnt[k] = 0; m_ph[k] = 1'b1;
      end else if (m_cnt[k] == BD[k] - 1) begin
        m_cnt[k] = 0; m_ph[k] = ~m_ph[k];
      end else begin
        m_cnt[k]++;
      end
      if (m_rem[k] > 0) begin
        m_rem[k]--;
        if (m_rem[k] == 0) m_shown[k] = m_pend[k];
      end else if (load) begin
        m_pend[k] = int'(fl) % (1 << FW[k]);
        m_rem[k]  = FW[k] + 1;
      end
    end
  endtask

  task automatic check_all();
    chk("seg_a", 64'(seg_a), exp_seg(0));
    chk("seg_b", 64'(seg_b), exp_seg(1));
    chk("seg_c", 64'(seg_c), exp_seg(2));
    chk("busy_a", 64'(busy_a), 64'(m_rem[0] > 0));
    chk("busy_b", 64'(busy_b), 64'(m_rem[1] > 0));
    chk("busy_c", 64'(busy_c), 64'(m_rem[2] > 0));
    chk("up_a", 64'(up_a), 64'(m_up));
    chk("dn_a", 64'(dn_a), 64'(m_dn));
    chk("up_b", 64'(up_b), 64'(m_up));
    chk("dn_c", 64'(dn_c), 64'(m_dn));
  endtask

  task automatic cycle(input logic ld, input logic mv, input logic du, input logic [9:0] f);
    load = ld; moving = mv; dir_up = du; fl = f;
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_async_seg_a", 64'(seg_a), 64'h003F);
    chk("rst_async_busy_a", 64'(busy_a), 64'd0);
    cycle(1'b0, 1'b0, 1'b0, 10'd0);
    cycle(1'b0, 1'b0, 1'b0, 10'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic mv_r, du_r;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_seg_a", 64'(seg_a), 64'h003F);
    rst_n = 1'b1;
    idle(2);

    // load 13: busy E0..E4, "13" at E5
    cycle(1'b1, 1'b0, 1'b0, 10'd13);
    idle(4);
    chk("busy_e4", 64'(busy_a), 64'd1);
    idle(1);
    chk("show13", 64'(seg_a), 64'h034F);
    chk("idle_e5", 64'(busy_a), 64'd0);
    idle(12);

    // load while busy is ignored
    cycle(1'b1, 1'b0, 1'b0, 10'd7);
    idle(1);
    cycle(1'b1, 1'b0, 1'b0, 10'd12);
    idle(3);
    chk("show7", 64'(seg_a), 64'h0007);
    cycle(1'b1, 1'b0, 1'b0, 10'd12);
    idle(5);
    chk("show12", 64'(seg_a), 64'h035B);
    idle(12);

    // single digit overflow, no blanking, active-low
    cycle(1'b1, 1'b0, 1'b0, 10'd12);
    idle(11);
    chk("c_ovf", 64'(seg_c), 64'h40);
    cycle(1'b1, 1'b0, 1'b0, 10'd9);
    idle(11);
    chk("c_nine", 64'(seg_c), 64'h6F);
    cycle(1'b1, 1'b0, 1'b0, 10'd5);
    idle(11);
    chk("b_nolzb5", 64'(seg_b), 64'h102012);
    chk("a_lzb5", 64'(seg_a), 64'h006D);
    cycle(1'b1, 1'b0, 1'b0, 10'd1010);
    idle(11);

    // blink while moving down, then steady
    cycle(1'b1, 1'b0, 1'b0, 10'd13);
    idle(11);
    repeat (13) cycle(1'b0, 1'b1, 1'b0, 10'd0);
    cycle(1'b0, 1'b0, 1'b0, 10'd0);
    chk("steady13", 64'(seg_a), 64'h034F);

    // reset mid-conversion
    cycle(1'b1, 1'b0, 1'b0, 10'd15);
    idle(2);
    pulse_reset();
    cycle(1'b1, 1'b0, 1'b0, 10'd15);
    idle(5);
    chk("show15", 64'(seg_a), 64'h036D);
    idle(8);

    mv_r = 1'b0;
    du_r = 1'b0;
    repeat (800) begin
      if ($urandom_range(0, 9) == 0) mv_r = ~mv_r;
      if ($urandom_range(0, 7) == 0) du_r = ~du_r;
      if ($urandom_range(0, 149) == 0) pulse_reset();
      else cycle($urandom_range(0, 2) == 0, mv_r, du_r,
                 ($urandom_range(0, 3) == 0) ? 10'(1000 + $urandom_range(0, 23))
                                             : 10'($urandom_range(0, 1023)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
